// File: rtl/pipe_hazard_ctrl.sv
// Purpose : central stall/flush sequencer for the 5-stage pipeline; resolves
//           multi-cycle data-memory waits (with timeout), taken branches and
//           load-use hazards into per-register enable/flush/bubble controls.
// Latency : all controls are combinational from FSM state and current inputs.
// Backpressure: a memory wait freezes PC, IF/ID, ID/EX, EX/MEM and bubbles
//           MEM/WB until Mem_Ack. A timeout parks the block in ERR until Rst.
// Ports   : Clk/Rst (sync, active-high); ID_Rs/ID_Rt, EX_MemRead/EX_Rt,
//           EX_BrTaken, Mem_Req/Mem_Ack in; PC_Write, IFID_Write, IFID_Flush,
//           IDEX_Bubble, PipeHold, MEMWB_Bubble, Mem_Err, Stall_Cycles out.
// Option  : define HAZARD_STALL_STATS_EN to count PC-stall cycles in
//           Stall_Cycles (saturating); otherwise it is tied to zero.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rt,
  input  logic        EX_BrTaken,
  input  logic        Mem_Req,
  input  logic        Mem_Ack,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
  output logic        PipeHold,
  output logic        MEMWB_Bubble,
  output logic        Mem_Err,
  output logic [31:0] Stall_Cycles
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;
  logic             freeze;
  logic             load_use;

  // A load in EX whose destination feeds the instruction in ID. r0 is never
  // a real dependency.
  assign load_use = EX_MemRead && (EX_Rt != 5'd0) &&
                    ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));

  // Next-state logic for the memory-wait FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    freeze    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        // Ack without a request is ignored; req+ack together is zero-wait.
        if (Mem_Req && !Mem_Ack) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (Mem_Ack) begin
          // Release cycle: MEM/WB captures the read data, pipe advances.
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          freeze = 1'b1;
          if (cnt_q < TIMEOUT_C) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            state_d   = ST_ERR;
            mem_err_d = 1'b1;
          end
        end
      end
      ST_ERR: begin
        freeze    = 1'b1;
        mem_err_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    if (Rst) begin
      state_d   = ST_RUN;
      cnt_d     = '0;
      mem_err_d = 1'b0;
    end
  end

  // Output decode: freeze > branch > load-use. Hazards seen during a freeze
  // stay visible because EX/ID are held, so they resolve on release.
  always_comb begin
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    PipeHold     = 1'b0;
    MEMWB_Bubble = 1'b0;
    Mem_Err      = 1'b0;

    if (!Rst) begin
      Mem_Err = mem_err_q;
      if (freeze) begin
        PC_Write     = 1'b0;
        IFID_Write   = 1'b0;
        PipeHold     = 1'b1;
        MEMWB_Bubble = 1'b1;
      end else if (EX_BrTaken) begin
        // Dependent instruction (if any) is flushed, so no load-use stall.
        IFID_Flush  = 1'b1;
        IDEX_Bubble = 1'b1;
      end else if (load_use) begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    state_q   <= state_d;
    cnt_q     <= cnt_d;
    mem_err_q <= mem_err_d;
  end

`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stall_q, stall_d;

  // Counts cycles in which the PC is held; flush-only cycles keep PC_Write=1.
  always_comb begin
    stall_d = stall_q;
    if (Rst) begin
      stall_d = 32'h0;
    end else if (!PC_Write && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    stall_q <= stall_d;
  end

  assign Stall_Cycles = Rst ? 32'h0 : stall_q;
`else
  assign Stall_Cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose : self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
// Latency : reference outputs are compared every cycle at the falling edge.
// Backpressure: n/a; stimulus is directed scenarios then random traffic.
module tb_pipe_hazard_ctrl;

  localparam int T = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
  logic        EX_MemRead, EX_BrTaken, Mem_Req, Mem_Ack;
  logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble;
  logic        PipeHold, MEMWB_Bubble, Mem_Err;
  logic [31:0] Stall_Cycles;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(3)) dut (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .EX_BrTaken(EX_BrTaken),
    .Mem_Req(Mem_Req), .Mem_Ack(Mem_Ack), .PC_Write(PC_Write),
    .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .PipeHold(PipeHold),
    .MEMWB_Bubble(MEMWB_Bubble), .Mem_Err(Mem_Err),
    .Stall_Cycles(Stall_Cycles)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: "waited" = freeze cycles already spent on the current
  // outstanding access (0 = no access pending); "err" = timed out.
  int          m_waited = 0;
  bit          m_err    = 1'b0;
  longint      m_stall  = 0;

  typedef struct packed {
    logic        pcw, ifw, flush, bubble, hold, memwb, err;
    logic [31:0] stall;
  } exp_t;

  function automatic exp_t model_out();
    exp_t e;
    bit frozen, lu;
    e = '0;
    e.pcw = 1'b1;
    e.ifw = 1'b1;
    if (Rst) return e;
    frozen = m_err || ((m_waited == 0) ? (Mem_Req && !Mem_Ack) : !Mem_Ack);
    lu = EX_MemRead && EX_Rt != 0 && (EX_Rt == ID_Rs || EX_Rt == ID_Rt);
    e.err = m_err;
`ifdef HAZARD_STALL_STATS_EN
    e.stall = 32'(m_stall);
`endif
    if (frozen) begin
      e.pcw = 0; e.ifw = 0; e.hold = 1; e.memwb = 1;
    end else if (EX_BrTaken) begin
      e.flush = 1; e.bubble = 1;
    end else if (lu) begin
      e.pcw = 0; e.ifw = 0; e.bubble = 1;
    end
    return e;
  endfunction

  always @(posedge Clk) begin
    exp_t e;
    e = model_out();
    if (Rst) begin
      m_waited <= 0; m_err <= 0; m_stall <= 0;
    end else begin
      if (!e.pcw && m_stall < 64'hFFFF_FFFF) m_stall <= m_stall + 1;
      if (!m_err) begin
        if (m_waited == 0) begin
          if (Mem_Req && !Mem_Ack) m_waited <= 1;
        end else if (Mem_Ack) m_waited <= 0;
        else if (m_waited < T) m_waited <= m_waited + 1;
        else m_err <= 1'b1;
      end
    end
  end

  // Compare process: outputs are meaningful every cycle.
  always @(negedge Clk) begin
    exp_t e;
    e = model_out();
    chk("cycle_outputs",
        {25'd0, PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, PipeHold,
         MEMWB_Bubble, Mem_Err, Stall_Cycles},
        {25'd0, e});
  end

  task automatic smp(); @(negedge Clk); endtask
  task automatic adv(); @(posedge Clk); #1; endtask
  task automatic idle();
    EX_MemRead = 0; EX_Rt = 0; ID_Rs = 0; ID_Rt = 0;
    EX_BrTaken = 0; Mem_Req = 0; Mem_Ack = 0;
  endtask
  task automatic do_reset();
    Rst = 1; adv(); Rst = 0;
  endtask

  initial begin
    logic [31:0] exp_stats;
    Rst = 1; idle();
    Mem_Req = 1; EX_BrTaken = 1;
    smp();
    chk("rst_pcw", PC_Write, 1);
    chk("rst_ifw", IFID_Write, 1);
    chk("rst_others", {IFID_Flush, IDEX_Bubble, PipeHold, MEMWB_Bubble, Mem_Err}, 0);
    adv(); idle(); Rst = 0;

    // Load-use stall: exactly one cycle.
    EX_MemRead = 1; EX_Rt = 5; ID_Rs = 5;
    smp();
    chk("lu_pcw", PC_Write, 0);
    chk("lu_ifw_bub", {IFID_Write, IDEX_Bubble}, 2'b01);
    adv(); idle();
    smp();
    chk("lu_release", {PC_Write, IDEX_Bubble}, 2'b10);
    adv();

    // Branch wins over a simultaneous load-use match (not a stall).
    EX_MemRead = 1; EX_Rt = 7; ID_Rt = 7; EX_BrTaken = 1;
    smp();
    chk("br_lu", {IFID_Flush, IDEX_Bubble, PC_Write}, 3'b111);
    adv(); idle();

    // Three-cycle memory wait, then ack.
    Mem_Req = 1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("memwait_freeze", {MEMWB_Bubble, PipeHold, PC_Write}, 3'b110);
      adv();
    end
    Mem_Ack = 1;
    smp();
    chk("memwait_ack", {MEMWB_Bubble, PipeHold, PC_Write}, 3'b001);
    adv(); idle();
    smp();
`ifdef HAZARD_STALL_STATS_EN
    exp_stats = 32'd4;
`else
    exp_stats = 32'd0;
`endif
    chk("stats_4", Stall_Cycles, exp_stats);
    adv();

    // Load in EX targeting r0 never stalls.
    EX_MemRead = 1; EX_Rt = 0; ID_Rs = 0; ID_Rt = 0;
    smp();
    chk("lu_r0", {PC_Write, IDEX_Bubble}, 2'b10);
    adv(); idle();

    // Zero-wait access.
    Mem_Req = 1; Mem_Ack = 1;
    smp();
    chk("zero_wait", {MEMWB_Bubble, PC_Write}, 2'b01);
    adv(); idle();

    // Branch held through a two-cycle wait acts only on release.
    EX_BrTaken = 1; Mem_Req = 1;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("br_frozen", IFID_Flush, 0);
      adv();
    end
    Mem_Ack = 1;
    smp();
    chk("br_release", {IFID_Flush, PC_Write}, 2'b11);
    adv(); idle();

    // Timeout: T+1 freeze cycles before ERR, then sticky until Rst.
    do_reset();
    Mem_Req = 1;
    for (int i = 0; i < T + 1; i++) begin
      smp();
      chk("to_no_err", {Mem_Err, PipeHold}, 2'b01);
      adv();
    end
    smp();
    chk("to_err", Mem_Err, 1);
    adv();
    Mem_Req = 0; Mem_Ack = 1; EX_BrTaken = 1;
    smp();
    chk("err_frozen", {PC_Write, PipeHold, IFID_Flush, Mem_Err}, 4'b0101);
    adv(); idle();
    do_reset();
    smp();
    chk("err_cleared", {Mem_Err, PC_Write}, 2'b01);
    adv();

    // Random traffic; small register range makes hazards frequent.
    for (int i = 0; i < 3000; i++) begin
      Rst        = ($urandom_range(0, 59) == 0);
      ID_Rs      = 5'($urandom_range(0, 3));
      ID_Rt      = 5'($urandom_range(0, 3));
      EX_Rt      = 5'($urandom_range(0, 3));
      EX_MemRead = 1'($urandom_range(0, 1));
      EX_BrTaken = ($urandom_range(0, 3) == 0);
      Mem_Req    = 1'($urandom_range(0, 1));
      Mem_Ack    = ($urandom_range(0, 3) == 0);
      adv();
    end
    Rst = 0; idle();
    smp();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves three hazard sources: multi-cycle data-memory access (req/ack handshake), load-use and taken branch.
- Contains a memory-wait FSM with timeout.

Parameters:
- MEM_TIMEOUT, 16, wait cycles in MEM_WAIT before declaring a memory error (>=1)
- CNT_W, 5, width of wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT

Ports:
- Clk  in  1  clock; all state updates on posedge
- Rst  in  1  reset, synchronous, active-high
- ID_Rs  in  5  rs field of instruction in ID
- ID_Rt  in  5  rt field of instruction in ID
- EX_MemRead  in  1  instruction in EX is a load
- EX_Rt  in  5  destination rt of instruction in EX
- EX_BrTaken  in  1  branch in EX resolved taken
- Mem_Req  in  1  level; instruction in MEM accesses data memory
- Mem_Ack  in  1  one-cycle pulse; data memory completes access this cycle
- PC_Write  out  1  PC load enable
- IFID_Write  out  1  IF/ID load enable
- IFID_Flush  out  1  IF/ID clears to NOP
- IDEX_Bubble  out  1  ID/EX loads zero control
- PipeHold  out  1  ID/EX and EX/MEM hold current contents
- MEMWB_Bubble  out  1  MEM/WB loads WB=2'b0 (no writeback)
- Mem_Err  out  1  sticky memory-timeout flag
- Stall_Cycles  out  32  stall statistics (see Optional Feature)

Behaviour:
- All outputs are combinational from FSM state and current inputs.
- While Rst=1 outputs are forced to: PC_Write=1, IFID_Write=1, all other outputs 0. Rst also sets state=RUN, counter=0, Mem_Err=0.
- FSM states: RUN, MEM_WAIT, ERR.
- Memory freeze (condition F) asserts: PC_Write=0, IFID_Write=0, PipeHold=1, MEMWB_Bubble=1, IFID_Flush=0, IDEX_Bubble=0.
- RUN:
  - Mem_Req=1 and Mem_Ack=0: F this cycle; next state MEM_WAIT; counter<=1.
  - Mem_Req=1 and Mem_Ack=1: zero-wait access, no freeze, stay in RUN.
  - Mem_Ack with Mem_Req=0: ignored.
- MEM_WAIT:
  - Mem_Ack=0 and counter<MEM_TIMEOUT: F; counter<=counter+1.
  - Mem_Ack=0 and counter==MEM_TIMEOUT: F; next state ERR; Mem_Err<=1.
  - Mem_Ack=1: no freeze this cycle (MEM/WB captures read data, pipe advances); next state RUN; counter<=0.
- ERR: F every cycle, Mem_Err=1; exits only via Rst.
- Hazard logic, evaluated only when not frozen:
  - Branch: EX_BrTaken=1 -> IFID_Flush=1, IDEX_Bubble=1, PC_Write=1 (PC loads target).
  - Load-use: EX_MemRead=1, EX_Rt!=0, and (EX_Rt==ID_Rs or EX_Rt==ID_Rt), with no taken branch -> PC_Write=0, IFID_Write=0, IDEX_Bubble=1, one cycle.
  - Priority: memory freeze > branch > load-use. Branch beats load-use because the dependent instruction is flushed anyway.
- A branch or load-use condition present during a freeze is not lost: EX/ID are held, so it is acted on in the release cycle.
- Rst mid-MEM_WAIT or in ERR: returns to RUN next cycle; no pending state is kept.

Optional Feature:
- Macro HAZARD_STALL_STATS_EN.
- Defined:
  - Stall_Cycles is a 32-bit counter, cleared by Rst.
  - Increments every cycle with PC_Write=0 (memory freeze or load-use); saturates at 32'hFFFF_FFFF.
  - Flush-only cycles are not counted.
- Undefined: Stall_Cycles tied to 32'h0, no counter logic.

Test Plan:
- Load-use: EX_MemRead=1, EX_Rt=5, ID_Rs=5 for one cycle -> PC_Write=0, IFID_Write=0, IDEX_Bubble=1 for exactly 1 cycle; with EX_Rt=0 -> no stall.
- Branch plus load-use: EX_BrTaken=1 with a load-use match in the same cycle -> IFID_Flush=1, IDEX_Bubble=1, PC_Write=1.
- Memory wait: Mem_Req=1, Mem_Ack pulses 3 cycles later -> 3 freeze cycles (MEMWB_Bubble=1, PipeHold=1), no freeze in the ack cycle, state back to RUN. Zero-wait case (Mem_Req and Mem_Ack together) -> no freeze.
- Timeout: MEM_TIMEOUT=4, Mem_Req=1, no ack -> freeze persists; Mem_Err=1 from the cycle after the 4th wait cycle; remains frozen until Rst; Rst clears Mem_Err.
- Branch during freeze: EX_BrTaken=1 throughout a 2-cycle memory wait -> IFID_Flush=0 while frozen, IFID_Flush=1 in the ack cycle.
- Stats (HAZARD_STALL_STATS_EN): 1 load-use stall + 3-cycle memory wait + 1 branch flush -> Stall_Cycles=4. Without the macro -> Stall_Cycles=0.
